// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and constants for the 1011 sequence path.
package seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, GAP = 2'b10, DONE = 2'b11} state_e;
  localparam logic [3:0] PAT_1011 = 4'b1011;
  localparam logic [6:0] LFSR_SEED = 7'h7F;
  localparam logic [6:0] LFSR_TAPS = 7'h60;
endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: request and serial-output bundle of the pattern transmitter.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] rep;
  logic [GAP_W-1:0] gap;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             done;
  modport master (output start, pattern, rep, gap, input x_out, x_valid, busy, done);
  modport slave  (input start, pattern, rep, gap, output x_out, x_valid, busy, done);
endinterface

// File: rtl/seq_lfsr7.sv
// seq_lfsr7: 7-bit Fibonacci LFSR, x^7+x^6+1, seeded on reset.
module seq_lfsr7
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [6:0] q
);
  logic [6:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = enable ? {lfsr_q[5:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
  end
  assign q = lfsr_q;
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: repeating MSB-first serial pattern transmitter with idle gaps.
// Define SEQ_TX_PRBS_IDLE_EN to drive LFSR noise on x_out while no pattern bit is sent.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_pattern_tx_if.slave        bus
);
  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);
  state_e           state_q, state_d;
  logic [PAT_W-1:0] sh_q, sh_d, pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_reg_q, gap_reg_d, gap_cnt_q, gap_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             x_out_q, x_out_d, x_valid_q, x_valid_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    gap_reg_d = gap_reg_q;
    gap_cnt_d = gap_cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d   = SEND;
        sh_d      = bus.pattern;
        pat_d     = bus.pattern;
        rep_d     = bus.rep;
        gap_reg_d = bus.gap;
        bit_cnt_d = LAST;
      end
      SEND: if (bit_cnt_q != '0) begin
        sh_d      = sh_q << 1;
        bit_cnt_d = bit_cnt_q - 1'b1;
      end else if (rep_q == '0) begin
        state_d = DONE;
      end else begin
        rep_d = rep_q - 1'b1;
        if (gap_reg_q == '0) begin
          sh_d      = pat_q;
          bit_cnt_d = LAST;
        end else begin
          state_d   = GAP;
          gap_cnt_d = gap_reg_q - 1'b1;
        end
      end
      GAP: if (gap_cnt_q == '0) begin
        state_d   = SEND;
        sh_d      = pat_q;
        bit_cnt_d = LAST;
      end else begin
        gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they arrive registered with it.
    x_valid_d = state_d == SEND;
    busy_d    = state_d != IDLE;
    done_d    = state_d == DONE;
    x_out_d   = x_valid_d & sh_d[PAT_W-1];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      pat_q     <= '0;
      rep_q     <= '0;
      gap_reg_q <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      gap_reg_q <= gap_reg_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
`ifdef SEQ_TX_PRBS_IDLE_EN
  logic [6:0] lfsr;
  seq_lfsr7 u_lfsr (.clk(clk), .reset(reset), .enable(1'b1), .q(lfsr));
  assign bus.x_out = x_valid_q ? x_out_q : lfsr[0];
`else
  assign bus.x_out = x_out_q;
`endif
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed checks of seq_pattern_tx timing, repeats, gaps, ignores and reset.
module tb_seq_pattern_tx;
  import seq_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  seq_pattern_tx_if #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) bus ();
  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
`ifdef SEQ_TX_PRBS_IDLE_EN
  logic [6:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 7'h7F;
    else m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end
  function automatic logic ib();
    return m_lfsr[0];
  endfunction
`else
  function automatic logic ib();
    return 1'b0;
  endfunction
`endif
  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  task automatic cyc(input string tag, input logic pb, input logic xv, input logic b, input logic d);
    logic [3:0] obs, exp_v;
    obs   = {bus.x_out, bus.x_valid, bus.busy, bus.done};
    exp_v = {xv ? pb : ib(), xv, b, d};
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed {x_out,x_valid,busy,done}=%b expected %b", tag, obs, exp_v);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] p;
    logic [7:0] e8, s;
    int hits, active;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pattern = '0;
    bus.rep = '0;
    bus.gap = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // single burst of 1011
    p = PAT_1011;
    bus.pattern = p;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.start = 1'b0;
      cyc("t1 bit", p[3-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    cyc("t1 done", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    cyc("t1 idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // two back-to-back bursts
    e8 = 8'b1011_1011;
    s = '0;
    bus.rep = 4'd1;
    bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.start = 1'b0;
      cyc("t2 bit", e8[7-i], 1'b1, 1'b1, 1'b0);
      s = {s[6:0], bus.x_out};
    end
    hits = 0;
    for (int j = 3; j < 8; j++) if (s[j-:4] == PAT_1011) hits++;
    chk("t2 detector hits", hits, 2);
    tick();
    cyc("t2 done", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    cyc("t2 idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // three bursts separated by 3-cycle gaps
    bus.rep = 4'd2;
    bus.gap = 4'd3;
    bus.start = 1'b1;
    active = 0;
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 4; b++) begin
        tick();
        bus.start = 1'b0;
        cyc("t3 bit", p[3-b], 1'b1, 1'b1, 1'b0);
        if (bus.busy && !bus.done) active++;
      end
      if (r < 2) for (int g = 0; g < 3; g++) begin
        tick();
        cyc("t3 gap", 1'b0, 1'b0, 1'b1, 1'b0);
        if (bus.busy && !bus.done) active++;
      end
    end
    tick();
    cyc("t3 done", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3 active cycles", active, 18);
    tick();
    cyc("t3 idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // start and new fields while busy are ignored
    bus.rep = '0;
    bus.gap = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b1;
    bus.pattern = 4'b0000;
    bus.rep = 4'd3;
    bus.gap = 4'd5;
    cyc("t4 bit0", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    bus.start = 1'b0;
    cyc("t4 bit1", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    cyc("t4 bit2", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    cyc("t4 bit3", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    cyc("t4 done", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    cyc("t4 idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // async reset at the second bit
    bus.pattern = PAT_1011;
    bus.rep = '0;
    bus.gap = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc("t5 bit0", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    cyc("t5 bit1", 1'b0, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 cyc("t5 async reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cyc("t5 in reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    cyc("t5 no done", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cyc("t5 still idle", 1'b0, 1'b0, 1'b0, 1'b0);
    p = 4'b0110;
    bus.pattern = p;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.start = 1'b0;
      cyc("t5 resend bit", p[3-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    cyc("t5 done", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    cyc("t5 idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // held start: retriggers after DONE plus one IDLE cycle
    p = 4'b1001;
    bus.pattern = p;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cyc("t6 bit", p[3-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    cyc("t6 done", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    cyc("t6 idle gap", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    cyc("t6 retrigger bit0", p[3], 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      cyc("t6 retrigger bit", p[3-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    cyc("t6 done2", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    cyc("t6 idle2", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
